// File: rtl/acc_ctrl_pkg.sv
// Shared definitions for the accumulator-machine controller: opcodes, ALU
// operation codes, FSM state encoding and the packed control word.
package acc_ctrl_pkg;

    localparam int OPCODE_W = 3;
    localparam int STATE_W  = 4;

    localparam logic [OPCODE_W-1:0] OP_LDA = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_STA = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_ADD = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_SUB = 3'b011;
    localparam logic [OPCODE_W-1:0] OP_AND = 3'b100;
    localparam logic [OPCODE_W-1:0] OP_NOT = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_JMP = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_JZ  = 3'b111;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_AND  = 3'b010;
    localparam logic [2:0] ALU_NOT  = 3'b011;
    localparam logic [2:0] ALU_PASS = 3'b100;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEM_RD = 4'd2,
        S_LD_WB  = 4'd3,
        S_ALU_EX = 4'd4,
        S_NOT_EX = 4'd5,
        S_ALU_WB = 4'd6,
        S_MEM_WR = 4'd7
    } state_t;

    typedef struct packed {
        logic       irwrite;
        logic       memread;
        logic       memwrite;
        logic       pcwrite;
        logic       pcsrc;
        logic       alusrc1;
        logic       alusrc2;
        logic [2:0] alucrtl;
        logic       accwrite;
        logic       memtoacc;
        logic       iord;
        logic       instr_done;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '0;

    // Two-operand arithmetic opcodes map onto the ALU select; others fall back to ADD.
    function automatic logic [2:0] alu_op_for(input logic [OPCODE_W-1:0] op);
        case (op)
            OP_SUB:  alu_op_for = ALU_SUB;
            OP_AND:  alu_op_for = ALU_AND;
            default: alu_op_for = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/acc_ctrl_decode.sv
// Combinational control-word decoder: current state, opcode and ALU zero flag
// in, datapath strobes out. Unknown state encodings decode to an idle word.
import acc_ctrl_pkg::*;

module acc_ctrl_decode #(
    parameter int OPW = 3
) (
    input  state_t         state,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    output ctrl_t          ctrl
);

    always_comb begin
        ctrl = CTRL_NONE;
        case (state)
            S_FETCH: begin
                ctrl.iord    = 1'b0;
                ctrl.memread = 1'b1;
                ctrl.irwrite = 1'b1;
                ctrl.alucrtl = ALU_ADD;
                ctrl.pcsrc   = 1'b0;
                ctrl.pcwrite = 1'b1;
            end
            S_DECODE: begin
                case (opcode)
                    OP_JMP: begin
                        ctrl.pcsrc      = 1'b1;
                        ctrl.pcwrite    = 1'b1;
                        ctrl.instr_done = 1'b1;
                    end
                    OP_JZ: begin
                        // A is passed through the ALU so zero reflects the accumulator.
                        ctrl.alusrc1    = 1'b1;
                        ctrl.alucrtl    = ALU_PASS;
                        ctrl.pcsrc      = zero;
                        ctrl.pcwrite    = zero;
                        ctrl.instr_done = 1'b1;
                    end
                    default: ctrl = CTRL_NONE;
                endcase
            end
            S_MEM_RD: begin
                ctrl.iord    = 1'b1;
                ctrl.memread = 1'b1;
            end
            S_LD_WB: begin
                ctrl.memtoacc   = 1'b1;
                ctrl.accwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_ALU_EX: begin
                ctrl.alusrc1 = 1'b1;
                ctrl.alusrc2 = 1'b1;
                ctrl.alucrtl = alu_op_for(opcode);
            end
            S_NOT_EX: begin
                ctrl.alusrc1 = 1'b1;
                ctrl.alucrtl = ALU_NOT;
            end
            S_ALU_WB: begin
                ctrl.memtoacc   = 1'b0;
                ctrl.accwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.iord       = 1'b1;
                ctrl.memwrite   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            default: ctrl = CTRL_NONE;
        endcase
    end

endmodule

// File: rtl/acc_controller.sv
// Multicycle FSM controller for the 16-bit accumulator datapath.
// Optional memory wait states are enabled by defining ACC_CTRL_MEM_WAIT_EN.
import acc_ctrl_pkg::*;

module acc_controller #(
    parameter int OPW = 3,
    parameter int SW  = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [15:0]   inst,
    input  logic          zero,
`ifdef ACC_CTRL_MEM_WAIT_EN
    input  logic          mem_ready,
`endif
    output logic          IRwrite,
    output logic          memread,
    output logic          memwrite,
    output logic          pcwrite,
    output logic          pcsrc,
    output logic          alusrc1,
    output logic          alusrc2,
    output logic [2:0]    alucrtl,
    output logic          accwrite,
    output logic          memtoacc,
    output logic          iord,
    output logic          instr_done,
    output logic [SW-1:0] dbg_state
);

    state_t         state_reg;
    state_t         state_next;
    logic [OPW-1:0] opcode;
    logic           mem_ok;
    ctrl_t          ctrl_raw;
    ctrl_t          ctrl_out;
    logic           unused_addr;

    assign opcode      = inst[15 -: OPW];
    assign unused_addr = ^inst[15-OPW:0];

`ifdef ACC_CTRL_MEM_WAIT_EN
    assign mem_ok = mem_ready;
`else
    assign mem_ok = 1'b1;
`endif

    acc_ctrl_decode #(
        .OPW (OPW)
    ) u_decode (
        .state  (state_reg),
        .opcode (opcode),
        .zero   (zero),
        .ctrl   (ctrl_raw)
    );

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH:  state_next = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_JMP, OP_JZ: state_next = S_FETCH;
                    OP_NOT:        state_next = S_NOT_EX;
                    OP_STA:        state_next = S_MEM_WR;
                    default:       state_next = S_MEM_RD;
                endcase
            end
            S_MEM_RD: begin
                if (!mem_ok)
                    state_next = S_MEM_RD;
                else if (opcode == OP_LDA)
                    state_next = S_LD_WB;
                else
                    state_next = S_ALU_EX;
            end
            S_LD_WB:  state_next = S_FETCH;
            S_ALU_EX: state_next = S_ALU_WB;
            S_NOT_EX: state_next = S_ALU_WB;
            S_ALU_WB: state_next = S_FETCH;
            S_MEM_WR: state_next = mem_ok ? S_FETCH : S_MEM_WR;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= S_FETCH;
        else
            state_reg <= state_next;
    end

    // While waiting on memory, only the side-effect-free strobes stay up so the
    // PC advances and the instruction retires exactly once. Reset masks everything.
    always_comb begin
        ctrl_out = ctrl_raw;
        if (state_reg == S_FETCH && !mem_ok) begin
            ctrl_out.irwrite = 1'b0;
            ctrl_out.pcwrite = 1'b0;
        end
        if (state_reg == S_MEM_WR && !mem_ok)
            ctrl_out.instr_done = 1'b0;
        if (!reset)
            ctrl_out = CTRL_NONE;
    end

    assign IRwrite    = ctrl_out.irwrite;
    assign memread    = ctrl_out.memread;
    assign memwrite   = ctrl_out.memwrite;
    assign pcwrite    = ctrl_out.pcwrite;
    assign pcsrc      = ctrl_out.pcsrc;
    assign alusrc1    = ctrl_out.alusrc1;
    assign alusrc2    = ctrl_out.alusrc2;
    assign alucrtl    = ctrl_out.alucrtl;
    assign accwrite   = ctrl_out.accwrite;
    assign memtoacc   = ctrl_out.memtoacc;
    assign iord       = ctrl_out.iord;
    assign instr_done = ctrl_out.instr_done;
    assign dbg_state  = SW'(state_reg);

endmodule

// File: tb/tb_acc_controller.sv
// Self-checking bench for acc_controller: per-instruction expected strobe
// sequences against randomized opcodes, addresses and zero flag.
module tb_acc_controller;
    import acc_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] inst = 16'h0000;
    logic        zero = 1'b0;
`ifdef ACC_CTRL_MEM_WAIT_EN
    logic        mem_ready = 1'b1;
`endif
    logic        IRwrite, memread, memwrite, pcwrite, pcsrc, alusrc1, alusrc2;
    logic [2:0]  alucrtl;
    logic        accwrite, memtoacc, iord, instr_done;
    logic [3:0]  dbg_state;
    logic [13:0] obs;

    int n_cmp = 0;
    int n_fail = 0;

    acc_controller #(.OPW(3), .SW(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .inst       (inst),
        .zero       (zero),
`ifdef ACC_CTRL_MEM_WAIT_EN
        .mem_ready  (mem_ready),
`endif
        .IRwrite    (IRwrite),
        .memread    (memread),
        .memwrite   (memwrite),
        .pcwrite    (pcwrite),
        .pcsrc      (pcsrc),
        .alusrc1    (alusrc1),
        .alusrc2    (alusrc2),
        .alucrtl    (alucrtl),
        .accwrite   (accwrite),
        .memtoacc   (memtoacc),
        .iord       (iord),
        .instr_done (instr_done),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    assign obs = {IRwrite, memread, memwrite, pcwrite, pcsrc, alusrc1, alusrc2,
                  alucrtl, accwrite, memtoacc, iord, instr_done};

    // Cycles each instruction class occupies, start of FETCH to retire.
    function automatic int cpi(input logic [2:0] op);
        case (op)
            3'b110, 3'b111: cpi = 2;
            3'b001:         cpi = 3;
            3'b000, 3'b101: cpi = 4;
            default:        cpi = 5;
        endcase
    endfunction

    // Expected strobes for cycle 'step' of an instruction with opcode 'op'.
    function automatic logic [13:0] exp_word(input logic [2:0] op, input int step, input logic z);
        logic irw, mr, mw, pcw, pcs, a1, a2, aw, mta, io, dn;
        logic [2:0] alu;
        {irw, mr, mw, pcw, pcs, a1, a2, aw, mta, io, dn} = '0;
        alu = 3'd0;
        if (step == 0) begin
            irw = 1'b1; mr = 1'b1; pcw = 1'b1;
        end else if (step == 1) begin
            if (op == 3'b110) begin
                pcs = 1'b1; pcw = 1'b1; dn = 1'b1;
            end else if (op == 3'b111) begin
                a1 = 1'b1; alu = 3'b100; pcs = z; pcw = z; dn = 1'b1;
            end
        end else begin
            case (op)
                3'b001: if (step == 2) begin io = 1'b1; mw = 1'b1; dn = 1'b1; end
                3'b000: begin
                    if (step == 2) begin io = 1'b1; mr = 1'b1; end
                    else if (step == 3) begin mta = 1'b1; aw = 1'b1; dn = 1'b1; end
                end
                3'b101: begin
                    if (step == 2) begin a1 = 1'b1; alu = 3'b011; end
                    else if (step == 3) begin aw = 1'b1; dn = 1'b1; end
                end
                default: begin
                    if (step == 2) begin io = 1'b1; mr = 1'b1; end
                    else if (step == 3) begin
                        a1 = 1'b1; a2 = 1'b1;
                        alu = (op == 3'b010) ? 3'b000 : (op == 3'b011) ? 3'b001 : 3'b010;
                    end else if (step == 4) begin aw = 1'b1; dn = 1'b1; end
                end
            endcase
        end
        return {irw, mr, mw, pcw, pcs, a1, a2, alu, aw, mta, io, dn};
    endfunction

    // Runs one whole instruction starting just after a falling edge in FETCH.
    // zmode: 0/1 forces zero, 2 randomizes it every cycle.
    task automatic run_instr(input logic [2:0] op, input logic [12:0] addr, input int zmode);
        int bad;
        logic [13:0] want;
        bad = 0;
        inst = {op, addr};
        for (int k = 0; k < cpi(op); k++) begin
            zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
            #1;
            want = exp_word(op, k, zero);
            n_cmp++;
            if (obs !== want) begin
                n_fail++; bad++;
                $display("FAIL ctrl op=%0d step=%0d zero=%0b got=%b want=%b", op, k, zero, obs, want);
            end
            if (k == 0) begin
                n_cmp++;
                if (dbg_state !== S_FETCH) begin
                    n_fail++; bad++;
                    $display("FAIL fetch_state op=%0d got=%0d want=%0d", op, dbg_state, S_FETCH);
                end
            end
            @(negedge clk);
        end
        $display("instr op=%0d addr=%h cycles=%0d errors=%0d", op, addr, cpi(op), bad);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (obs !== 14'd0 || dbg_state !== S_FETCH) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d got=%b/%0d want=0/%0d", i, obs, dbg_state, S_FETCH);
            end
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({memread, IRwrite, pcwrite} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_release got=%b want=111", {memread, IRwrite, pcwrite});
        end
        $display("reset held 3 cycles then released");
    endtask

    task automatic test_add();
        run_instr(3'b010, 13'h0005, 2);
    endtask

    task automatic test_jz();
        run_instr(3'b111, 13'h0010, 1);
        run_instr(3'b111, 13'h0010, 0);
    endtask

    task automatic test_sta_not();
        run_instr(3'b001, 13'h0003, 2);
        run_instr(3'b101, 13'h0000, 2);
    endtask

    task automatic test_reset_mid();
        inst = {3'b011, 13'h0042};
        for (int k = 0; k < 4; k++) begin
            zero = 1'($urandom_range(0, 1));
            #1;
            n_cmp++;
            if (obs !== exp_word(3'b011, k, zero)) begin
                n_fail++;
                $display("FAIL sub_pre step=%0d got=%b want=%b", k, obs, exp_word(3'b011, k, zero));
            end
            if (k < 3) @(negedge clk);
        end
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 14'd0 || dbg_state !== S_FETCH) begin
            n_fail++;
            $display("FAIL reset_async got=%b/%0d want=0/%0d", obs, dbg_state, S_FETCH);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (accwrite !== 1'b0 || obs !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_mid cyc=%0d got=%b want=0", i, obs);
            end
        end
        @(negedge clk);
        reset = 1'b1;
        $display("reset pulsed during SUB ALU_EX");
        run_instr(3'b011, 13'h0042, 2);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++)
            run_instr(3'($urandom_range(0, 7)), 13'($urandom), 2);
    endtask

`ifdef ACC_CTRL_MEM_WAIT_EN
    task automatic test_mem_wait();
        logic [13:0] want;
        inst = {3'b110, 13'h0100};
        want = exp_word(3'b110, 0, 1'b0) & ~14'b10_0100_0000_0000;
        mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++;
            if (obs !== want || dbg_state !== S_FETCH) begin
                n_fail++;
                $display("FAIL fetch_wait cyc=%0d got=%b/%0d want=%b/%0d", i, obs, dbg_state, want, S_FETCH);
            end
            @(negedge clk);
        end
        mem_ready = 1'b1;
        run_instr(3'b110, 13'h0100, 0);
        $display("fetch held for 2 wait cycles");
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_jz();
        test_sta_not();
        test_reset_mid();
`ifdef ACC_CTRL_MEM_WAIT_EN
        test_mem_wait();
`endif
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
